// File: rtl/radar_track_arbiter_if.sv
// Bundle between the track arbiter, its requesters and the target-tracking unit.
// Pure wiring, no latency.
// No backpressure: requests are level samples, results are single-cycle pulses.
interface radar_track_arbiter_if;
    logic [3:0]  req;
    logic        ttu_target_locked;
    logic [13:0] ttu_distance;
    logic [1:0]  ttu_state;
    logic        track_target_command;
    logic [3:0]  grant;
    logic        busy;
    logic        result_valid;
    logic [1:0]  result_id;
    logic [13:0] result_distance;
    logic        result_timeout;

    // Requester / tracking-unit side
    modport master (
        output req, ttu_target_locked, ttu_distance, ttu_state,
        input  track_target_command, grant, busy, result_valid,
               result_id, result_distance, result_timeout
    );

    // Arbiter side
    modport slave (
        input  req, ttu_target_locked, ttu_distance, ttu_state,
        output track_target_command, grant, busy, result_valid,
               result_id, result_distance, result_timeout
    );
endinterface

// File: rtl/radar_track_arbiter.sv
// Arbitrates 4 requesters for one tracking unit: command, wait for lock or timeout, report, cool down.
// Latency: grant one edge after pending seen with tracking unit IDLE; result CMD_CYC + wait + 1 edges later.
// Backpressure: requests wait in pending bits while busy or ttu_state != IDLE; macro TRACK_ARB_STRICT_PRIORITY_EN selects fixed priority.
module radar_track_arbiter #(
    parameter int unsigned TIMEOUT_CYC = 200,
    parameter int unsigned CMD_CYC     = 2,
    parameter int unsigned GUARD_CYC   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    radar_track_arbiter_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CMD       = 3'd1,
        WAIT_LOCK = 3'd2,
        REPORT    = 3'd3,
        COOLDOWN  = 3'd4
    } state_t;

    localparam logic [7:0]  CMD_LAST   = 8'(CMD_CYC - 1);
    localparam logic [7:0]  GUARD_LAST = 8'(GUARD_CYC - 1);
    localparam logic [15:0] TO_LAST    = 16'(TIMEOUT_CYC - 1);

    state_t      state_q, state_d;
    logic [3:0]  pending_q, pending_d;
    logic [1:0]  rr_ptr_q, rr_ptr_d;
    logic [3:0]  grant_q, grant_d;
    logic [1:0]  gidx_q, gidx_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] timer_q, timer_d;
    logic        cmd_q, cmd_d;
    logic        res_vld_q, res_vld_d;
    logic [1:0]  res_id_q, res_id_d;
    logic [13:0] res_dist_q, res_dist_d;
    logic        res_to_q, res_to_d;

    logic [3:0]  clr_mask;
    logic        sel_found;
    logic [1:0]  sel_idx;
    logic [1:0]  cand;

    // Pick the next requester among pending bits.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
`ifdef TRACK_ARB_STRICT_PRIORITY_EN
        // Descending scan so the lowest pending index is the last (winning) hit.
        for (int i = 3; i >= 0; i--) begin
            if (pending_q[i]) begin
                sel_found = 1'b1;
                sel_idx   = 2'(i);
            end
        end
`else
        // Descending offset scan from the pointer so the nearest index after the last grant wins.
        for (int i = 3; i >= 0; i--) begin
            cand = rr_ptr_q + 2'(i);
            if (pending_q[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
`endif
    end

    // Next-state and output-register logic for the session FSM.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_d    = grant_q;
        gidx_d     = gidx_q;
        cnt_d      = cnt_q;
        timer_d    = timer_q;
        cmd_d      = 1'b0;
        res_vld_d  = 1'b0;
        res_id_d   = res_id_q;
        res_dist_d = res_dist_q;
        res_to_d   = res_to_q;
        clr_mask   = 4'b0000;

        unique case (state_q)
            IDLE: begin
                if (sel_found && (bus.ttu_state == 2'b00)) begin
                    state_d  = CMD;
                    grant_d  = 4'b0001 << sel_idx;
                    gidx_d   = sel_idx;
                    rr_ptr_d = sel_idx + 2'd1;
                    cnt_d    = '0;
                    cmd_d    = 1'b1;
                end
            end
            CMD: begin
                if (cnt_q == CMD_LAST) begin
                    state_d = WAIT_LOCK;
                    timer_d = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    cmd_d = 1'b1;
                end
            end
            WAIT_LOCK: begin
                // Lock is checked first so a lock on the last timer cycle still reports a distance.
                if (bus.ttu_target_locked) begin
                    state_d    = REPORT;
                    res_vld_d  = 1'b1;
                    res_id_d   = gidx_q;
                    res_dist_d = bus.ttu_distance;
                    res_to_d   = 1'b0;
                end else if (timer_q == TO_LAST) begin
                    state_d    = REPORT;
                    res_vld_d  = 1'b1;
                    res_id_d   = gidx_q;
                    res_dist_d = '0;
                    res_to_d   = 1'b1;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            REPORT: begin
                clr_mask = grant_q;
                grant_d  = '0;
                cnt_d    = '0;
                state_d  = COOLDOWN;
            end
            COOLDOWN: begin
                if (cnt_q == GUARD_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase

        // A new request in the REPORT cycle re-arms the bit being cleared.
        pending_d = (pending_q & ~clr_mask) | bus.req;
    end

    // State and datapath registers; reset aborts any session without a result pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pending_q  <= '0;
            rr_ptr_q   <= '0;
            grant_q    <= '0;
            gidx_q     <= '0;
            cnt_q      <= '0;
            timer_q    <= '0;
            cmd_q      <= 1'b0;
            res_vld_q  <= 1'b0;
            res_id_q   <= '0;
            res_dist_q <= '0;
            res_to_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_q    <= grant_d;
            gidx_q     <= gidx_d;
            cnt_q      <= cnt_d;
            timer_q    <= timer_d;
            cmd_q      <= cmd_d;
            res_vld_q  <= res_vld_d;
            res_id_q   <= res_id_d;
            res_dist_q <= res_dist_d;
            res_to_q   <= res_to_d;
        end
    end

    assign bus.track_target_command = cmd_q;
    assign bus.grant                = grant_q;
    assign bus.busy                 = (state_q != IDLE);
    assign bus.result_valid         = res_vld_q;
    assign bus.result_id            = res_id_q;
    assign bus.result_distance      = res_dist_q;
    assign bus.result_timeout       = res_to_q;

endmodule

// File: tb/tb_radar_track_arbiter.sv
// Directed bench for radar_track_arbiter with default parameters (TIMEOUT 200, CMD 2, GUARD 4).
// Inputs change 1 time unit after the rising edge; outputs are sampled at that same point.
// Expected values are hand-derived; macro TRACK_ARB_STRICT_PRIORITY_EN switches arbitration expectations.
module tb_radar_track_arbiter;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    radar_track_arbiter_if bus();

    radar_track_arbiter #(
        .TIMEOUT_CYC (200),
        .CMD_CYC     (2),
        .GUARD_CYC   (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Grant must never have more than one bit set.
    always @(negedge clk) begin
        checks++;
        if (!$onehot0(bus.grant)) begin
            errors++;
            $display("FAIL grant_onehot: got %b required at most one bit", bus.grant);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int limit, output int cyc, output bit ok);
        cyc = 0;
        ok  = 1'b0;
        while (cyc < limit && !ok) begin
            tick();
            cyc++;
            if (bus.result_valid === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic wait_wlock(output bit ok);
        bit seen = 1'b0;
        ok = 1'b0;
        for (int n = 0; n < 20 && !ok; n++) begin
            tick();
            if (bus.track_target_command === 1'b1) seen = 1'b1;
            else if (seen) ok = 1'b1;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (n < 50 && bus.busy !== 1'b0) begin
            tick();
            n++;
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL wait_idle: busy=%b still after 50 cycles, required 0", bus.busy);
        end
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req = '0;
        bus.ttu_target_locked = 1'b0;
        bus.ttu_distance = '0;
        bus.ttu_state = 2'b00;
        tick();
        tick();
        checks++;
        if ({bus.track_target_command, bus.grant, bus.busy, bus.result_valid, bus.result_id,
             bus.result_distance, bus.result_timeout} !== 24'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %h required 000000",
                     {bus.track_target_command, bus.grant, bus.busy, bus.result_valid,
                      bus.result_id, bus.result_distance, bus.result_timeout});
        end
        rst = 1'b0;
        tick();
        checks++;
        if (bus.busy !== 1'b0 || bus.grant !== 4'b0000) begin
            errors++;
            $display("FAIL reset_idle: busy=%b grant=%b required 0/0000", bus.busy, bus.grant);
        end
    endtask

    task automatic test_single_lock();
        bus.req = 4'b0010;
        tick();
        bus.req = '0;
        tick();
        checks++;
        if (bus.grant !== 4'b0010 || bus.track_target_command !== 1'b1) begin
            errors++;
            $display("FAIL lock_grant: grant=%b cmd=%b required 0010/1", bus.grant, bus.track_target_command);
        end
        tick();
        checks++;
        if (bus.track_target_command !== 1'b1) begin
            errors++;
            $display("FAIL lock_cmd2: cmd=%b required 1", bus.track_target_command);
        end
        tick();
        checks++;
        if (bus.track_target_command !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL lock_cmd_end: cmd=%b busy=%b required 0/1", bus.track_target_command, bus.busy);
        end
        repeat (4) tick();
        bus.ttu_distance = 14'd1500;
        bus.ttu_target_locked = 1'b1;
        tick();
        checks++;
        if ({bus.result_valid, bus.result_id, bus.result_distance, bus.result_timeout} !==
            {1'b1, 2'd1, 14'd1500, 1'b0}) begin
            errors++;
            $display("FAIL lock_result: vld=%b id=%0d dist=%0d to=%b required 1/1/1500/0",
                     bus.result_valid, bus.result_id, bus.result_distance, bus.result_timeout);
        end
        bus.ttu_target_locked = 1'b0;
        bus.ttu_distance = '0;
        tick();
        checks++;
        if (bus.result_valid !== 1'b0 || bus.grant !== 4'b0000 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL lock_cooldown: vld=%b grant=%b busy=%b required 0/0000/1",
                     bus.result_valid, bus.grant, bus.busy);
        end
        checks++;
        if (bus.result_id !== 2'd1 || bus.result_distance !== 14'd1500 || bus.result_timeout !== 1'b0) begin
            errors++;
            $display("FAIL lock_hold: id=%0d dist=%0d to=%b required 1/1500/0",
                     bus.result_id, bus.result_distance, bus.result_timeout);
        end
        repeat (3) tick();
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL guard_len: busy=%b in last cooldown cycle required 1", bus.busy);
        end
        tick();
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL guard_end: busy=%b after cooldown required 0", bus.busy);
        end
        tick();
        tick();
        checks++;
        if (bus.grant !== 4'b0000) begin
            errors++;
            $display("FAIL pending_cleared: grant=%b required 0000", bus.grant);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int cyc;
        bus.req = 4'b0001;
        tick();
        bus.req = '0;
        wait_wlock(ok);
        checks++;
        if (!ok || bus.grant !== 4'b0001) begin
            errors++;
            $display("FAIL to_start: reached=%b grant=%b required 1/0001", ok, bus.grant);
        end
        wait_valid(300, cyc, ok);
        checks++;
        if (!ok || cyc != 200) begin
            errors++;
            $display("FAIL to_latency: seen=%b cycles=%0d required 1/200", ok, cyc);
        end
        checks++;
        if (bus.result_timeout !== 1'b1 || bus.result_distance !== 14'd0 || bus.result_id !== 2'd0) begin
            errors++;
            $display("FAIL to_result: to=%b dist=%0d id=%0d required 1/0/0",
                     bus.result_timeout, bus.result_distance, bus.result_id);
        end
        wait_idle();
    endtask

    task automatic test_round_robin();
        bit ok;
        int cyc;
        pulse_rst();
        bus.ttu_target_locked = 1'b1;
        bus.ttu_distance = 14'd777;
        bus.req = 4'b1111;
        tick();
        bus.req = '0;
        for (int k = 0; k < 4; k++) begin
            wait_valid(50, cyc, ok);
            checks++;
            if (!ok || bus.grant !== (4'b0001 << k) || bus.result_id !== 2'(k) ||
                bus.result_distance !== 14'd777) begin
                errors++;
                $display("FAIL rr_order[%0d]: seen=%b grant=%b id=%0d dist=%0d required 1/%b/%0d/777",
                         k, ok, bus.grant, bus.result_id, bus.result_distance, 4'b0001 << k, k);
            end
        end
        bus.ttu_target_locked = 1'b0;
        wait_idle();
    endtask

    task automatic test_back_to_back();
        bit ok;
        int cyc;
        logic [1:0] exp_ids [3];
`ifdef TRACK_ARB_STRICT_PRIORITY_EN
        exp_ids = '{2'd1, 2'd0, 2'd2};
`else
        exp_ids = '{2'd1, 2'd2, 2'd0};
`endif
        pulse_rst();
        bus.ttu_target_locked = 1'b1;
        bus.ttu_distance = 14'd42;
        bus.req = 4'b0010;
        tick();
        bus.req = 4'b0101;
        tick();
        bus.req = '0;
        for (int k = 0; k < 3; k++) begin
            wait_valid(50, cyc, ok);
            checks++;
            if (!ok || bus.result_id !== exp_ids[k]) begin
                errors++;
                $display("FAIL b2b_order[%0d]: seen=%b id=%0d required 1/%0d", k, ok, bus.result_id, exp_ids[k]);
            end
        end
        bus.ttu_target_locked = 1'b0;
        wait_idle();
    endtask

    task automatic test_ttu_busy();
        bit ok;
        int cyc;
        int bad = 0;
        bus.ttu_state = 2'b11;
        bus.req = 4'b0100;
        tick();
        bus.req = '0;
        for (int n = 0; n < 8; n++) begin
            tick();
            if (bus.grant !== 4'b0000 || bus.busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL ttu_hold: %0d cycles granted while ttu busy, required 0", bad);
        end
        bus.ttu_state = 2'b00;
        tick();
        checks++;
        if (bus.grant !== 4'b0100) begin
            errors++;
            $display("FAIL ttu_release: grant=%b required 0100", bus.grant);
        end
        bus.ttu_target_locked = 1'b1;
        wait_valid(50, cyc, ok);
        checks++;
        if (!ok || bus.result_id !== 2'd2) begin
            errors++;
            $display("FAIL ttu_result: seen=%b id=%0d required 1/2", ok, bus.result_id);
        end
        bus.ttu_target_locked = 1'b0;
        wait_idle();
    endtask

    task automatic test_reset_mid_cmd();
        bit ok;
        int cyc;
        int bad = 0;
        bus.req = 4'b1000;
        tick();
        bus.req = '0;
        tick();
        tick();
        checks++;
        if (bus.track_target_command !== 1'b1 || bus.grant !== 4'b1000) begin
            errors++;
            $display("FAIL abort_setup: cmd=%b grant=%b required 1/1000", bus.track_target_command, bus.grant);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({bus.track_target_command, bus.grant, bus.busy, bus.result_valid, bus.result_id,
             bus.result_distance, bus.result_timeout} !== 24'h0) begin
            errors++;
            $display("FAIL abort_outputs: got %h required 000000",
                     {bus.track_target_command, bus.grant, bus.busy, bus.result_valid,
                      bus.result_id, bus.result_distance, bus.result_timeout});
        end
        for (int n = 0; n < 20; n++) begin
            tick();
            if (bus.result_valid !== 1'b0 || bus.grant !== 4'b0000 || bus.busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL abort_quiet: %0d active cycles after abort, required 0", bad);
        end
        bus.ttu_target_locked = 1'b1;
        bus.ttu_distance = 14'd900;
        bus.req = 4'b1000;
        tick();
        bus.req = '0;
        wait_valid(50, cyc, ok);
        checks++;
        if (!ok || bus.result_id !== 2'd3 || bus.result_distance !== 14'd900) begin
            errors++;
            $display("FAIL abort_rerequest: seen=%b id=%0d dist=%0d required 1/3/900",
                     ok, bus.result_id, bus.result_distance);
        end
        bus.ttu_target_locked = 1'b0;
        wait_idle();
    endtask

    task automatic test_lock_timeout_same();
        bit ok;
        bus.req = 4'b0001;
        tick();
        bus.req = '0;
        wait_wlock(ok);
        repeat (199) tick();
        checks++;
        if (!ok || bus.result_valid !== 1'b0) begin
            errors++;
            $display("FAIL tie_setup: reached=%b vld=%b required 1/0", ok, bus.result_valid);
        end
        bus.ttu_target_locked = 1'b1;
        bus.ttu_distance = 14'd4321;
        tick();
        checks++;
        if ({bus.result_valid, bus.result_timeout, bus.result_distance} !== {1'b1, 1'b0, 14'd4321}) begin
            errors++;
            $display("FAIL tie_lock_wins: vld=%b to=%b dist=%0d required 1/0/4321",
                     bus.result_valid, bus.result_timeout, bus.result_distance);
        end
        bus.ttu_target_locked = 1'b0;
        wait_idle();
    endtask

    initial begin
        test_reset();
        test_single_lock();
        test_timeout();
        test_round_robin();
        test_back_to_back();
        test_ttu_busy();
        test_reset_mid_cmd();
        test_lock_timeout_same();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/radar_track_arbiter.md
RADAR_TRACK_ARBITER -- requirements
Module: radar_track_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 200: WAIT_LOCK cycles before a request is abandoned (1..65535).
REQ-002 SHALL have parameter CMD_CYC, default 2: cycles track_target_command is held high (1..255).
REQ-003 SHALL have parameter GUARD_CYC, default 4: COOLDOWN cycles between tracking sessions (1..255).
REQ-004 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port req, input, 4: per-requester track request; a high sample sets that requester's pending bit.
REQ-007 SHALL have port ttu_target_locked, input, 1: lock flag from the tracking unit.
REQ-008 SHALL have port ttu_distance, input, 14: distance from the tracking unit.
REQ-009 SHALL have port ttu_state, input, 2: tracking-unit state; 2'b00 = IDLE.
REQ-010 SHALL have port track_target_command, output, 1: command to the tracking unit.
REQ-011 SHALL have port grant, output, 4: one-hot owner of the current session; zero when none.
REQ-012 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-013 SHALL have port result_valid, output, 1: one-cycle completion pulse.
REQ-014 SHALL have port result_id, output, 2: index of the completed requester.
REQ-015 SHALL have port result_distance, output, 14: captured distance; 0 on timeout.
REQ-016 SHALL have port result_timeout, output, 1: high when the session ended without lock.

Function
REQ-017 SHALL implement FSM states IDLE, CMD, WAIT_LOCK, REPORT and COOLDOWN.
REQ-018 SHALL, in IDLE, when pending is non-zero and ttu_state==2'b00, select one requester, drive grant, and enter CMD on the next edge.
REQ-019 SHALL select by round-robin, starting at the index after the last granted requester (index 0 first after reset).
REQ-020 SHALL hold track_target_command high for exactly CMD_CYC cycles in CMD, then enter WAIT_LOCK with a 16-bit timer cleared.
REQ-021 SHALL, in WAIT_LOCK, capture ttu_distance into result_distance, clear result_timeout, and enter REPORT when ttu_target_locked==1.
REQ-022 SHALL, in WAIT_LOCK, when the timer reaches TIMEOUT_CYC-1 without lock, set result_timeout, set result_distance to 0, and enter REPORT.
REQ-023 SHALL give lock priority over timeout when both occur in the same cycle.
REQ-024 SHALL, in REPORT, pulse result_valid for one cycle with result_id set to the granted index, clear that pending bit, and enter COOLDOWN.
REQ-025 SHALL keep the pending bit set when req for that index is high in the REPORT cycle (set wins over clear).
REQ-026 SHALL hold grant stable from CMD through REPORT and drop it to 0 on entering COOLDOWN.
REQ-027 SHALL spend GUARD_CYC cycles in COOLDOWN and then return to IDLE.
REQ-028 SHALL hold result_id, result_distance and result_timeout stable until the next REPORT.
REQ-029 SHALL keep grant at most one-hot at all times.

Reset
REQ-030 SHALL, on rst sampled high, clear pending and the timers and set state=IDLE, track_target_command=0, grant=0, busy=0, result_valid=0, result_id=0, result_distance=0, result_timeout=0, round-robin pointer=0.
REQ-031 SHALL treat rst in any state, including mid-command, as abort: no result_valid pulse and all request state discarded.

Configuration
REQ-032 SHALL support macro TRACK_ARB_STRICT_PRIORITY_EN.
- Defined: fixed priority; the lowest pending index always wins.
- Undefined: round-robin per REQ-019.

Verification
REQ-033 SHALL cover this scenario: req=4'b0010 pulse, lock 5 cycles into WAIT_LOCK with ttu_distance=1500 -> grant=4'b0010, command high 2 cycles, result_valid with id=1, distance=1500, timeout=0.
REQ-034 SHALL cover this scenario: req=4'b0001, no lock -> result_valid exactly 200 cycles after entering WAIT_LOCK, with timeout=1 and distance=0.
REQ-035 SHALL cover this scenario: req=4'b1111 held one cycle, lock each session -> grants in order 0,1,2,3 (macro undefined); order 0 first with the macro defined.
REQ-036 SHALL cover this scenario: pending set while ttu_state==2'b11 -> no grant until ttu_state==2'b00.
REQ-037 SHALL cover this scenario: rst asserted during the second CMD cycle -> all outputs at reset values next edge, no result_valid, re-request serviced normally.
REQ-038 SHALL cover this scenario: lock and timeout in the same cycle -> timeout=0 and the captured distance is reported.
